// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI bus arbiter: requester indices, state
// encoding, default timing parameters and the grant selection helper.
package spi_arb_pkg;

    localparam int N_MASTERS = 3;

    localparam int IDX_GAIN = 0;
    localparam int IDX_ADC  = 1;
    localparam int IDX_DAC  = 2;

    localparam int DEF_TIMEOUT_CYCLES = 256;
    localparam int DEF_GAP_CYCLES     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_e;

    // Gain always wins; adc/dac share the bus round robin, but a lone
    // requester wins regardless of which one is currently preferred.
    function automatic logic [N_MASTERS-1:0] pick_grant(
        input logic [N_MASTERS-1:0] req,
        input logic                 prefer_dac
    );
        logic [N_MASTERS-1:0] sel;
        sel = '0;
        if (req[IDX_GAIN]) begin
            sel[IDX_GAIN] = 1'b1;
        end else if (req[IDX_ADC] && req[IDX_DAC]) begin
            if (prefer_dac) sel[IDX_DAC] = 1'b1;
            else            sel[IDX_ADC] = 1'b1;
        end else if (req[IDX_ADC]) begin
            sel[IDX_ADC] = 1'b1;
        end else if (req[IDX_DAC]) begin
            sel[IDX_DAC] = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/spi_bus_arbiter_if.sv
// Bundle of the per-master request/transfer signals and the shared bus.
// The master modport is the view of the sequencing side, the slave modport
// is the view of the arbiter.
interface spi_arb_if;
    import spi_arb_pkg::*;

    logic [N_MASTERS-1:0] req;
    logic [N_MASTERS-1:0] done;
    logic [N_MASTERS-1:0] sck_in;
    logic [N_MASTERS-1:0] mosi_in;
    logic [N_MASTERS-1:0] grant;
    logic                 sck;
    logic                 mosi;

    modport master (
        output req, done, sck_in, mosi_in,
        input  grant, sck, mosi
    );

    modport slave (
        input  req, done, sck_in, mosi_in,
        output grant, sck, mosi
    );

endinterface

// File: rtl/spi_bus_mux.sv
// Grant-masked OR of the per-master SPI clock and data onto the shared bus.
// With a zero grant the bus idles low.
module spi_bus_mux #(
    parameter int N = 3
) (
    input  logic [N-1:0] grant,
    input  logic [N-1:0] sck_in,
    input  logic [N-1:0] mosi_in,
    output logic         sck,
    output logic         mosi
);

    assign sck  = |(sck_in  & grant);
    assign mosi = |(mosi_in & grant);

endmodule

// File: rtl/spi_bus_arbiter.sv
// Arbiter for the shared Starter Kit SPI bus: registered one-hot grant,
// fixed gain priority, adc/dac round robin, grant timeout with a sticky
// error flag, and an idle gap after every release.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES
) (
    input  logic      clock,
    input  logic      reset,
    spi_arb_if.slave  bus,
    output logic      busy,
    output logic      timeout_err,
    output logic      spissb,
    output logic      sf_ce0,
    output logic      fpgainitb
);

    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    arb_state_e           state, state_nxt;
    logic [N_MASTERS-1:0] grant, grant_nxt;
    logic                 prefer_dac, prefer_dac_nxt;
    logic [TO_W-1:0]      hold_cnt, hold_cnt_nxt;
    logic [GAP_W-1:0]     gap_cnt, gap_cnt_nxt;
    logic                 err_flag, err_flag_nxt;
    logic                 done_hit;
    logic                 timeout_hit;
    logic                 bus_sck;
    logic                 bus_mosi;

    // Only the granted master's done counts; a done landing on the timeout
    // cycle is treated as a normal completion.
    assign done_hit    = |(bus.done & grant);
    assign timeout_hit = (hold_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Next-state, next-grant, pointer and counter logic.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        prefer_dac_nxt = prefer_dac;
        hold_cnt_nxt   = hold_cnt;
        gap_cnt_nxt    = gap_cnt;
        err_flag_nxt   = err_flag;
        case (state)
            ST_IDLE: begin
                if (|bus.req) begin
                    grant_nxt    = pick_grant(bus.req, prefer_dac);
                    hold_cnt_nxt = '0;
                    state_nxt    = ST_GRANT;
                    if (grant_nxt[IDX_ADC])      prefer_dac_nxt = 1'b1;
                    else if (grant_nxt[IDX_DAC]) prefer_dac_nxt = 1'b0;
                end
            end
            ST_GRANT: begin
                if (done_hit || timeout_hit) begin
                    grant_nxt   = '0;
                    gap_cnt_nxt = '0;
                    state_nxt   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    if (!done_hit) err_flag_nxt = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_nxt   = ST_IDLE;
                else                                   gap_cnt_nxt = gap_cnt + 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // State register; reset abandons any transfer without flagging an error.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant      <= '0;
            prefer_dac <= 1'b0;
            hold_cnt   <= '0;
            gap_cnt    <= '0;
            err_flag   <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            prefer_dac <= prefer_dac_nxt;
            hold_cnt   <= hold_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
            err_flag   <= err_flag_nxt;
        end
    end

    spi_bus_mux #(.N(N_MASTERS)) u_mux (
        .grant   (grant),
        .sck_in  (bus.sck_in),
        .mosi_in (bus.mosi_in),
        .sck     (bus_sck),
        .mosi    (bus_mosi)
    );

    assign bus.grant   = grant;
    assign bus.sck     = bus_sck;
    assign bus.mosi    = bus_mosi;
    assign busy        = (state != ST_IDLE);
    assign timeout_err = err_flag;

    // Other devices on the shared bus are held deselected at all times.
    assign spissb    = 1'b1;
    assign sf_ce0    = 1'b1;
    assign fpgainitb = 1'b1;

endmodule
